// File: rtl/rob_mp_if.sv
// rtl/rob_mp_if.sv - allocation, writeback, commit and control bundle for the reorder buffer
interface rob_mp_if #(
    parameter int ALLOC_W  = 2,
    parameter int COMMIT_W = 2,
    parameter int WB_PORTS = 2,
    parameter int ARCH_W   = 5,
    parameter int PTAG_W   = 6,
    parameter int CAUSE_W  = 4,
    parameter int IDX_W    = 5
);
    // allocation from rename/dispatch
    logic [ALLOC_W-1:0]                 alloc_valid;
    logic [ALLOC_W-1:0]                 alloc_has_rd;
    logic [ALLOC_W-1:0][ARCH_W-1:0]     alloc_arch_rd;
    logic [ALLOC_W-1:0][PTAG_W-1:0]     alloc_phys_rd;
    logic [ALLOC_W-1:0][PTAG_W-1:0]     alloc_old_phys;
    logic                               alloc_ready;
    logic [ALLOC_W-1:0][IDX_W-1:0]      alloc_idx;
    // writeback / mark-ready
    logic [WB_PORTS-1:0]                wb_valid;
    logic [WB_PORTS-1:0][IDX_W-1:0]     wb_idx;
    logic [WB_PORTS-1:0]                wb_exc;
    logic [WB_PORTS-1:0][CAUSE_W-1:0]   wb_cause;
    // commit to arch state / freelist
    logic [COMMIT_W-1:0]                commit_valid;
    logic [COMMIT_W-1:0]                commit_has_rd;
    logic [COMMIT_W-1:0][ARCH_W-1:0]    commit_arch_rd;
    logic [COMMIT_W-1:0][PTAG_W-1:0]    commit_phys_rd;
    logic [COMMIT_W-1:0][PTAG_W-1:0]    commit_old_phys;
    // exception report
    logic                               exc_valid;
    logic [IDX_W-1:0]                   exc_idx;
    logic [CAUSE_W-1:0]                 exc_cause;
    // recovery controls
    logic                               squash_en;
    logic [IDX_W-1:0]                   squash_idx;
    logic                               flush_all;
    // occupancy
    logic [IDX_W:0]                     rob_count;
    logic                               rob_empty;
    logic                               rob_full;

    modport master (
        output alloc_valid, alloc_has_rd, alloc_arch_rd, alloc_phys_rd, alloc_old_phys,
        input  alloc_ready, alloc_idx,
        output wb_valid, wb_idx, wb_exc, wb_cause,
        input  commit_valid, commit_has_rd, commit_arch_rd, commit_phys_rd, commit_old_phys,
        input  exc_valid, exc_idx, exc_cause,
        output squash_en, squash_idx, flush_all,
        input  rob_count, rob_empty, rob_full
    );

    modport slave (
        input  alloc_valid, alloc_has_rd, alloc_arch_rd, alloc_phys_rd, alloc_old_phys,
        output alloc_ready, alloc_idx,
        input  wb_valid, wb_idx, wb_exc, wb_cause,
        output commit_valid, commit_has_rd, commit_arch_rd, commit_phys_rd, commit_old_phys,
        output exc_valid, exc_idx, exc_cause,
        input  squash_en, squash_idx, flush_all,
        output rob_count, rob_empty, rob_full
    );
endinterface

// File: rtl/rob_mp.sv
// rtl/rob_mp.sv - multi-port reorder buffer with partial squash and exception hold
module rob_mp #(
    parameter int ROB_SIZE = 32,
    parameter int ALLOC_W  = 2,
    parameter int COMMIT_W = 2,
    parameter int WB_PORTS = 2,
    parameter int ARCH_W   = 5,
    parameter int PTAG_W   = 6,
    parameter int CAUSE_W  = 4
) (
    input  logic     clk,
    input  logic     reset,
    rob_mp_if.slave  bus
);
    localparam int IDX_W = $clog2(ROB_SIZE);
    localparam int PTR_W = IDX_W + 1;

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_EXC_HOLD = 1'b1;

    // pointers carry a wrap bit above the index so full and empty are distinguishable
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [0:0]         state;

    // per-entry status flags
    logic [ROB_SIZE-1:0] e_valid;
    logic [ROB_SIZE-1:0] e_ready;
    logic [ROB_SIZE-1:0] e_exc;

    // per-entry payload, meaningful only while the entry is valid
    logic [ROB_SIZE-1:0] e_has_rd;
    logic [ARCH_W-1:0]   e_arch   [ROB_SIZE];
    logic [PTAG_W-1:0]   e_phys   [ROB_SIZE];
    logic [PTAG_W-1:0]   e_old    [ROB_SIZE];
    logic [CAUSE_W-1:0]  e_cause  [ROB_SIZE];

    logic [IDX_W-1:0]    h_low;
    logic [PTR_W-1:0]    count;
    logic [PTR_W-1:0]    free_slots;
    logic                head_exc;

    logic [ALLOC_W-1:0][IDX_W-1:0] alloc_slot;
    logic [PTR_W-1:0]    alloc_n;
    logic                alloc_ok;
    logic                alloc_fire;

    logic [COMMIT_W-1:0]            commit_ok;
    logic [COMMIT_W-1:0][IDX_W-1:0] commit_slot;
    logic [PTR_W-1:0]               commit_n;

    logic [ROB_SIZE-1:0] wb_hit;
    logic [ROB_SIZE-1:0] wb_any_exc;
    logic [CAUSE_W-1:0]  wb_cause_sel [ROB_SIZE];
    logic [ROB_SIZE-1:0] wb_take;

    logic [IDX_W-1:0]    sq_off;
    logic [PTR_W-1:0]    sq_tail;
    logic [ROB_SIZE-1:0] sq_kill;

    assign h_low      = head[IDX_W-1:0];
    assign count      = tail - head;
    assign free_slots = PTR_W'(ROB_SIZE) - count;
    assign head_exc   = e_valid[h_low] && e_ready[h_low] && e_exc[h_low];

    assign alloc_ok   = (free_slots >= PTR_W'(ALLOC_W)) && (state == ST_RUN);
    assign alloc_fire = alloc_ok && (|bus.alloc_valid) && !bus.squash_en && !bus.flush_all;

    // squash keeps head..squash_idx, so the new tail is one past it in head-relative order
    assign sq_off  = bus.squash_idx - h_low;
    assign sq_tail = head + {1'b0, sq_off} + PTR_W'(1);

    assign bus.alloc_ready = alloc_ok;
    assign bus.alloc_idx   = alloc_slot;
    assign bus.rob_count   = count;
    assign bus.rob_empty   = (count == '0);
    assign bus.rob_full    = (count == PTR_W'(ROB_SIZE));
    assign bus.exc_valid   = head_exc;
    assign bus.exc_idx     = h_low;
    assign bus.exc_cause   = head_exc ? e_cause[h_low] : '0;

    // pack requesting lanes onto consecutive slots starting at tail
    always_comb begin : alloc_lanes
        logic [PTR_W-1:0] acc;
        acc = '0;
        for (int k = 0; k < ALLOC_W; k++) begin
            alloc_slot[k] = tail[IDX_W-1:0] + acc[IDX_W-1:0];
            if (bus.alloc_valid[k]) acc = acc + PTR_W'(1);
        end
        alloc_n = acc;
    end

    // in-order commit: each lane needs every older lane to commit as well
    always_comb begin : commit_lanes
        logic chain;
        chain       = (state == ST_RUN) && !bus.flush_all;
        commit_ok   = '0;
        commit_slot = '0;
        commit_n    = '0;
        for (int j = 0; j < COMMIT_W; j++) begin
            commit_slot[j] = h_low + IDX_W'(j);
            chain = chain && (PTR_W'(j) < count) && e_valid[commit_slot[j]]
                    && e_ready[commit_slot[j]] && !e_exc[commit_slot[j]];
            commit_ok[j] = chain;
            if (chain) commit_n = commit_n + PTR_W'(1);
        end
    end

    // commit outputs read straight from the entries at head
    always_comb begin
        bus.commit_valid    = commit_ok;
        bus.commit_has_rd   = '0;
        bus.commit_arch_rd  = '0;
        bus.commit_phys_rd  = '0;
        bus.commit_old_phys = '0;
        for (int j = 0; j < COMMIT_W; j++) begin
            bus.commit_has_rd[j]   = e_has_rd[commit_slot[j]];
            bus.commit_arch_rd[j]  = e_arch[commit_slot[j]];
            bus.commit_phys_rd[j]  = e_phys[commit_slot[j]];
            bus.commit_old_phys[j] = e_old[commit_slot[j]];
        end
    end

    // merge writeback ports per entry; scanning down lets the lowest excepting port own the cause
    always_comb begin
        for (int i = 0; i < ROB_SIZE; i++) begin
            wb_hit[i]       = 1'b0;
            wb_any_exc[i]   = 1'b0;
            wb_cause_sel[i] = '0;
            for (int p = WB_PORTS - 1; p >= 0; p--) begin
                if (bus.wb_valid[p] && (bus.wb_idx[p] == IDX_W'(i))) begin
                    wb_hit[i] = 1'b1;
                    if (bus.wb_exc[p]) begin
                        wb_any_exc[i]   = 1'b1;
                        wb_cause_sel[i] = bus.wb_cause[p];
                    end
                end
            end
        end
    end

    // entries strictly younger than squash_idx but still inside the occupied window are killed
    always_comb begin
        for (int i = 0; i < ROB_SIZE; i++) begin
            sq_kill[i] = bus.squash_en
                         && ({1'b0, IDX_W'(i) - h_low} > {1'b0, sq_off})
                         && ({1'b0, IDX_W'(i) - h_low} < count);
            wb_take[i] = wb_hit[i] && e_valid[i] && !sq_kill[i] && !bus.flush_all;
        end
    end

    // status flags: writeback, then commit release, squash kill and allocation in rising precedence
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_valid <= '0;
            e_ready <= '0;
            e_exc   <= '0;
        end else if (bus.flush_all) begin
            e_valid <= '0;
        end else begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                if (wb_take[i]) begin
                    e_ready[i] <= 1'b1;
                    if (wb_any_exc[i]) e_exc[i] <= 1'b1;
                end
            end
            for (int j = 0; j < COMMIT_W; j++) begin
                if (commit_ok[j]) e_valid[commit_slot[j]] <= 1'b0;
            end
            for (int i = 0; i < ROB_SIZE; i++) begin
                if (sq_kill[i]) e_valid[i] <= 1'b0;
            end
            if (alloc_fire) begin
                for (int k = 0; k < ALLOC_W; k++) begin
                    if (bus.alloc_valid[k]) begin
                        e_valid[alloc_slot[k]] <= 1'b1;
                        e_ready[alloc_slot[k]] <= 1'b0;
                        e_exc[alloc_slot[k]]   <= 1'b0;
                    end
                end
            end
        end
    end

    // payload capture at allocation and exception cause capture at writeback
    always_ff @(posedge clk) begin
        for (int i = 0; i < ROB_SIZE; i++) begin
            if (wb_take[i] && wb_any_exc[i]) e_cause[i] <= wb_cause_sel[i];
        end
        if (alloc_fire) begin
            for (int k = 0; k < ALLOC_W; k++) begin
                if (bus.alloc_valid[k]) begin
                    e_has_rd[alloc_slot[k]] <= bus.alloc_has_rd[k];
                    e_arch[alloc_slot[k]]   <= bus.alloc_arch_rd[k];
                    e_phys[alloc_slot[k]]   <= bus.alloc_phys_rd[k];
                    e_old[alloc_slot[k]]    <= bus.alloc_old_phys[k];
                end
            end
        end
    end

    // pointers and the run / exception-hold state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            state <= ST_RUN;
        end else begin
            head <= head + commit_n;
            if (bus.flush_all) begin
                // commits are suppressed during flush, so head is already head_next
                tail  <= head;
                state <= ST_RUN;
            end else begin
                if (bus.squash_en)   tail <= sq_tail;
                else if (alloc_fire) tail <= tail + alloc_n;
                if ((state == ST_RUN) && head_exc) state <= ST_EXC_HOLD;
            end
        end
    end
endmodule
